// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 commit tracker: retire record layout and tracker states.
package slc3_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned WORD_W     = 16;

    typedef struct packed {
        logic [WORD_W-1:0]     pc;
        logic                  wb_en;
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     data;
    } commit_rec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        PAUSED = 2'd2
    } tracker_state_e;

endpackage

// File: rtl/slc3_stall_watchdog.sv
// Per-instruction stall watchdog: saturating in-flight cycle counter with a sticky flag.
module slc3_stall_watchdog #(
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic stall
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             stall_d;

    // A new fetch restarts the count; counting freezes once the limit is reached.
    always_comb begin
        cnt_d   = cnt;
        stall_d = stall;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt != LIMIT)) begin
            cnt_d = cnt + CNT_W'(1);
        end
        if (cnt_d == LIMIT) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            stall <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            stall <= stall_d;
        end
    end

endmodule

// File: rtl/slc3_commit_tracker.sv
// Builds one retire record per SLC-3 instruction from fetch, register-write and pause
// activity; also counts retirements and watches for instructions that never finish.
module slc3_commit_tracker
    import slc3_pkg::*;
#(
    parameter int unsigned COUNT_W     = 32,
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_i,
    input  logic [WORD_W-1:0]     pc_i,
    input  logic                  ld_reg_i,
    input  logic [REG_ADDR_W-1:0] dr_i,
    input  logic [WORD_W-1:0]     bus_i,
    input  logic                  pause_i,
    output logic                  commit_valid,
    output logic [WORD_W-1:0]     commit_pc,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [WORD_W-1:0]     wb_data,
    output logic [COUNT_W-1:0]    commit_count_o,
    output logic                  stall_o
);

    tracker_state_e state;
    tracker_state_e state_d;
    commit_rec_t    cur;
    commit_rec_t    cur_d;
    commit_rec_t    wr_rec;
    commit_rec_t    fetch_rec;
    commit_rec_t    ret_rec;
    logic           retire;
    logic           pause_q;

    // Next-state and retire decision; a write coincident with fetch/pause belongs to the retiring record.
    always_comb begin
        state_d   = state;
        cur_d     = cur;
        retire    = 1'b0;
        fetch_rec = '{pc: pc_i, wb_en: 1'b0, rd: '0, data: '0};
        wr_rec    = cur;
        if (ld_reg_i) begin
            wr_rec.wb_en = 1'b1;
            wr_rec.rd    = dr_i;
            wr_rec.data  = bus_i;
        end
        ret_rec = wr_rec;
        unique case (state)
            IDLE, PAUSED: begin
                if (fetch_i) begin
                    cur_d   = fetch_rec;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cur_d = wr_rec;
                if (fetch_i) begin
                    retire = 1'b1;
                    cur_d  = fetch_rec;
                end else if (pause_i && !pause_q) begin
                    retire  = 1'b1;
                    state_d = PAUSED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cur     <= '0;
            pause_q <= 1'b0;
        end else begin
            state   <= state_d;
            cur     <= cur_d;
            pause_q <= pause_i;
        end
    end

    // Retire record holds between commits; rd/data are forced to zero when nothing was written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid   <= 1'b0;
            commit_pc      <= '0;
            wb_en          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            commit_count_o <= '0;
        end else begin
            commit_valid <= retire;
            if (retire) begin
                commit_pc      <= ret_rec.pc;
                wb_en          <= ret_rec.wb_en;
                wb_rd          <= ret_rec.wb_en ? ret_rec.rd : '0;
                wb_data        <= ret_rec.wb_en ? ret_rec.data : '0;
                commit_count_o <= commit_count_o + COUNT_W'(1);
            end
        end
    end

    slc3_stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (fetch_i),
        .count_en(state == EXEC),
        .stall   (stall_o)
    );

endmodule

// File: doc/slc3_commit_tracker.md
Name: slc3_commit_tracker

Overview:
- Sits in processor_top between the SLC-3 control FSM/datapath and the top-level debug nets.
- Watches fetch, register-file writes and pause entry.
- Emits one retire record per instruction on commit_valid/commit_pc/wb_en/wb_rd/wb_data, the commit stream the simulation bench consumes.
- Also keeps a retired-instruction counter and a per-instruction stall watchdog.

Parameters:
- COUNT_W, 32, width of commit_count_o; wraps modulo 2^COUNT_W.
- STALL_LIMIT, 64, max cycles one instruction may stay in flight before stall_o sets; legal range 2..65535.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_i  in  1  one-cycle strobe when the control FSM enters the first fetch state (MAR<-PC).
- pc_i  in  16  address of the instruction being fetched; valid when fetch_i=1.
- ld_reg_i  in  1  register-file write enable this cycle.
- dr_i  in  3  destination register of the write.
- bus_i  in  16  data written to the register file.
- pause_i  in  1  high while the FSM sits in a pause state.
- commit_valid  out  1  one-cycle retire strobe.
- commit_pc  out  16  PC of the retired instruction.
- wb_en  out  1  retired instruction wrote a register.
- wb_rd  out  3  register written.
- wb_data  out  16  value written.
- commit_count_o  out  COUNT_W  number of retired instructions.
- stall_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - In-flight capture registers cleared; watchdog counter 0.
  - Reset mid-instruction discards the in-flight instruction; no commit is emitted for it.
- States: IDLE (nothing in flight), EXEC (instruction in flight), PAUSED.
- IDLE:
  - fetch_i -> latch pc_i into cur_pc, clear cur_wb, go to EXEC.
  - ld_reg_i is ignored.
  - pause_i is ignored.
- EXEC:
  - ld_reg_i -> cur_wb=1, cur_rd=dr_i, cur_data=bus_i. Multiple writes: last one wins.
  - fetch_i -> retire the in-flight record; latch new cur_pc; cur_wb cleared; stay in EXEC.
    - If ld_reg_i and fetch_i are high in the same cycle, the write belongs to the retiring instruction and is included in its record.
  - Rising edge of pause_i (pause_i=1, previous cycle 0) with no fetch_i -> retire, go to PAUSED.
  - fetch_i takes priority over pause_i in the same cycle.
- PAUSED:
  - ld_reg_i is ignored.
  - fetch_i -> latch, go to EXEC.
  - pause_i may stay high indefinitely.
- Retire timing:
  - commit_valid is registered, high exactly one cycle, in the cycle after the retiring event.
  - commit_pc, wb_en, wb_rd and wb_data update in that same cycle and hold until the next commit.
  - When wb_en=0, wb_rd and wb_data are driven 0.
- Counter: commit_count_o increments in the same cycle commit_valid is high; wraps to 0 after all-ones.
- Watchdog:
  - Counter cleared on every fetch_i; increments each EXEC cycle.
  - Saturates at STALL_LIMIT.
  - On reaching STALL_LIMIT, stall_o sets and stays set until reset.
  - Not counted in IDLE or PAUSED.
- Back-to-back fetch_i on consecutive cycles is legal: one commit per fetch after the first, on consecutive cycles.

Decomposition:
- Shared package slc3_pkg:
  - commit_rec_t, packed {pc[15:0], wb_en, rd[2:0], data[15:0]}.
  - Tracker state enum {IDLE, EXEC, PAUSED}.
  - REG_ADDR_W=3 and WORD_W=16 constants.
- One natural sub-module: slc3_stall_watchdog, holding the saturating counter and sticky flag.
- Capture, FSM and commit output stay in the top module.

Test Plan:
- Reset low 8 cycles, then fetch_i with pc_i=0x3000, ld_reg_i dr=2 bus=0x0005 two cycles later, then fetch_i pc=0x3001.
  - Next cycle: commit_valid=1, commit_pc=0x3000, wb_en=1, wb_rd=2, wb_data=0x0005, commit_count_o=1.
- fetch_i pc=0x3001, no writes, fetch_i pc=0x3002.
  - commit_pc=0x3001, wb_en=0, wb_rd=0, wb_data=0.
- ld_reg_i dr=7 bus=0xBEEF in the same cycle as fetch_i pc=0x3003; two writes dr=1 then dr=4 bus=0x1234 in one instruction.
  - The 0xBEEF write is credited to the retiring PC.
  - The double-write instruction retires with wb_rd=4, wb_data=0x1234.
- fetch_i pc=0x3010, then pause_i rises for 20 cycles, then fetch_i pc=0x3011.
  - One commit for 0x3010 the cycle after the pause edge.
  - No further commits while paused; stall_o stays 0.
- fetch_i pc=0x4000, then no further fetch for 70 cycles with STALL_LIMIT=64.
  - stall_o=1 from cycle 64 onward and remains 1 after the next fetch.
- reset_n pulsed low mid-EXEC after ld_reg_i.
  - All outputs 0 immediately, no commit is emitted for the discarded PC, and commit_count_o=0.
